// File: rtl/mont_redu_sched.sv
// Round-robin two-requester scheduler feeding the shared Montgomery reducer through one issue register.
// Latency: accept to rsp strobe is BASE_LAT+mode+2 cycles. Backpressure: rN_ready drops while the
// requested result slot is already reserved; responses have none. Optional MONT_SCHED_STATS_EN adds counters.
module mont_redu_sched #(
  parameter int BASE_LAT = 3,
  parameter int W        = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [W-1:0] r0_a,
  input  logic [W-1:0] r0_b,
  input  logic [W-1:0] r0_q,
  input  logic [1:0]   r0_mode,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [W-1:0] r1_a,
  input  logic [W-1:0] r1_b,
  input  logic [W-1:0] r1_q,
  input  logic [1:0]   r1_mode,
  output logic [W-1:0] mr_a,
  output logic [W-1:0] mr_b,
  output logic [W-1:0] mr_q,
  output logic [1:0]   mr_i,
  input  logic [W-1:0] mr_res,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp_data
`ifdef MONT_SCHED_STATS_EN
  ,
  output logic [31:0]  stat_issued,
  output logic [31:0]  stat_stall
`endif
);

  localparam int NB = BASE_LAT + 6;
  localparam int SW = $clog2(NB);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [1:0]   mode;
  } req_t;

  // Result slot, counted in cycles ahead of the accept cycle.
  function automatic logic [SW-1:0] slot_of(input logic [1:0] m);
    return SW'(BASE_LAT + 2) + SW'(m);
  endfunction

  logic [NB-1:0] busy, tag;
  logic [NB-1:0] busy_sh, tag_sh, busy_nxt, tag_nxt;
  logic          elig0, elig1, gnt_any, gnt_id, rr_ptr;
  logic [SW-1:0] gslot;
  req_t          req0, req1, sel;

  always_comb begin
    req0 = '{a: r0_a, b: r0_b, q: r0_q, mode: r0_mode};
    req1 = '{a: r1_a, b: r1_b, q: r1_q, mode: r1_mode};

    // Shifted view: bit k set means a result lands k cycles after the current one.
    busy_sh = busy >> 1;
    tag_sh  = tag >> 1;

    elig0   = !reset && r0_valid && !busy_sh[slot_of(r0_mode)];
    elig1   = !reset && r1_valid && !busy_sh[slot_of(r1_mode)];
    gnt_any = elig0 || elig1;
    gnt_id  = (elig0 && elig1) ? rr_ptr : elig1;

    r0_ready = elig0 && !gnt_id;
    r1_ready = elig1 && gnt_id;

    sel   = gnt_id ? req1 : req0;
    gslot = slot_of(sel.mode);

    busy_nxt = busy_sh;
    tag_nxt  = tag_sh;
    if (gnt_any) begin
      busy_nxt[gslot] = 1'b1;
      tag_nxt[gslot]  = gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      tag        <= '0;
      rr_ptr     <= 1'b0;
      mr_a       <= '0;
      mr_b       <= '0;
      mr_q       <= '0;
      mr_i       <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_data   <= '0;
    end else begin
      busy <= busy_nxt;
      tag  <= tag_nxt;
      if (elig0 && elig1)
        rr_ptr <= ~rr_ptr;
      if (gnt_any) begin
        mr_a <= sel.a;
        mr_b <= sel.b;
        mr_q <= sel.q;
        mr_i <= sel.mode;
      end
      // The reducer output is only meaningful in a reserved slot.
      rsp0_valid <= busy_sh[1] && !tag_sh[1];
      rsp1_valid <= busy_sh[1] && tag_sh[1];
      if (busy_sh[1])
        rsp_data <= mr_res;
    end
  end

`ifdef MONT_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (gnt_any)
        stat_issued <= stat_issued + 32'd1;
      if ((r0_valid || r1_valid) && !gnt_any)
        stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mont_redu_sched.md
# mont_redu_sched

Two-requester scheduler in front of the shared Montgomery reducer. Requester 0 is the NTT butterfly and requester 1 is the twiddle/precompute path. The block accepts operand requests over valid/ready, arbitrates round-robin, and drives the reducer's A/B/q/i inputs through one issue register. Because reducer latency depends on the reduction mode, the block keeps an output-slot reservation vector so that no two results ever land in the same cycle. It returns each result to the requester that issued it.

## Interface
- BASE_LAT, 3: cycles from reducer operands presented to `mr_res` valid for mode 0. Mode m adds m cycles.
- W, 32: operand and result width.
- clk  in  1: clock.
- reset  in  1: reset, synchronous, active-high.
- r0_valid / r1_valid  in  1: request valid.
- r0_ready / r1_ready  out  1: request accepted when valid&ready.
- r0_a, r0_b, r0_q / r1_a, r1_b, r1_q  in  W: operands and modulus.
- r0_mode / r1_mode  in  2: reduction rounds minus 1 (0..3).
- mr_a, mr_b, mr_q  out  W: reducer operands.
- mr_i  out  2: reducer mode.
- mr_res  in  W: reducer result.
- rsp0_valid / rsp1_valid  out  1: one-cycle result strobe. No backpressure; the requester must sink it.
- rsp_data  out  W: registered result, shared by both response channels.

## Operation
- Result slot offset for an accept at cycle t with mode m: D(m) = BASE_LAT + m + 2.
- busy vector has BASE_LAT+6 bits; bit k means a result is due k cycles ahead. It shifts down by one every cycle.
- A requester is eligible when its valid is high and busy[D(mode)] is clear after this cycle's shift.
- rN_ready = eligible AND granted. Ready is combinational from valid/mode/busy/pointer, so a requester must not make valid depend on ready.
- Arbitration:
  - Both requesters eligible: grant `rr_ptr`, then set `rr_ptr` to the other requester.
  - One requester eligible: grant it, and leave `rr_ptr` unchanged.
  - At most one grant per cycle.
- On grant:
  - Register operands into mr_a/mr_b/mr_q/mr_i.
  - Set busy[D(mode)].
  - Write the requester id into tag pipe position D(mode).
- No grant: mr_a, mr_b and mr_q hold their value, and mr_i holds its value. The reducer output is ignored because its slot is not reserved.
- Output stage: when busy[1] is set, capture mr_res into rsp_data and assert rsp{tag}_valid the next cycle.
- A pending request with a blocked slot stalls (ready low) until its slot frees. Operands must be held stable while valid is high.
- Modulus and mode may differ per request. No ordering is guaranteed across different modes; results from one requester can return out of order if its modes differ.

## Timing
- Accept at t → mr_* valid at t+1 → mr_res at t+1+BASE_LAT+m → rsp at t+D(m). With BASE_LAT=3, mode 0 gives 5 cycles and mode 3 gives 8 cycles.
- Throughput is one accept per cycle when the modes are non-conflicting.
- Conflict example: mode 3 accepted at t and mode 0 requested at t+3 both target t+8. The second request stalls one cycle.
- Reset values:
  - busy = 0, tag pipe = 0, rr_ptr = 0.
  - rN_ready = 0 during reset.
  - rsp0_valid = rsp1_valid = 0, rsp_data = 0.
  - mr_a = mr_b = mr_q = 0, mr_i = 0.
- Reset mid-operation: all outstanding results are dropped and no rsp strobes follow. Reducer pipeline contents are ignored.

## Configuration
- MONT_SCHED_STATS_EN defined:
  - adds `stat_issued` (out, 32), counting grants;
  - adds `stat_stall` (out, 32), counting cycles where some valid is high with no grant;
  - both counters wrap and reset to 0.
- MONT_SCHED_STATS_EN undefined: both ports and both counters are absent. Behaviour is otherwise identical.

## Test plan
- Bench stub: `mr_res` is driven by a free-running cycle counter `cnt`.
- Single request: r0 mode 0 accepted at cycle 10 → rsp0_valid only at cycle 15, rsp_data = cnt value of cycle 14, rsp1_valid stays 0.
- Slot conflict: r0 mode 3 accepted at t=20, then r1 mode 0 valid from t=23 → r1_ready low at 23 and high at 24. Responses: rsp0 at 28, rsp1 at 29.
- Round-robin: both requesters valid continuously with mode 1, starting after reset → grants alternate r0, r1, r0, r1. rsp strobes alternate at 1 per cycle from cycle +6.
- Mixed modes, single requester: r0 issues mode 2 then mode 0 back-to-back → mode 0 response returns first, with no overlap.
- Reset mid-flight: 4 requests outstanding, reset held 1 cycle → no rsp strobes afterward, busy is clear, and the next request completes with nominal latency.
- Stats build: 3 grants and 2 stall cycles → stat_issued = 3, stat_stall = 2.
